// File: rtl/asym_sync_fifo_if.sv
// Bus bundle for asym_sync_fifo: write stream in, read stream out, plus occupancy status.
// A word moves on a rising edge only when its valid and ready are both high; valid never waits on ready.
interface asym_sync_fifo_if #(
  parameter int WR_DW = 32,
  parameter int RD_DW = 8,
  parameter int CNT_W = 9
);
  logic             wr_valid;
  logic             wr_ready;
  logic [WR_DW-1:0] wr_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [RD_DW-1:0] rd_data;
  logic [CNT_W-1:0] level;
  logic             empty;
  logic             full;

  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data, level, empty, full
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data, level, empty, full
  );
endinterface

// File: rtl/asym_sync_fifo.sv
// Single-clock width-converting FIFO: unit-granular RAM of MIN_DW slices, FWFT read side
// with a registered output word. level counts units in memory plus the output stage.
module asym_sync_fifo #(
  parameter int WR_DW     = 32,
  parameter int RD_DW     = 8,
  parameter int WR_AW     = 6,
  parameter bit LSB_FIRST = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  asym_sync_fifo_if.slave bus
);
  localparam int MIN_DW      = (WR_DW < RD_DW) ? WR_DW : RD_DW;
  localparam int WR_UNITS    = WR_DW / MIN_DW;
  localparam int RD_UNITS    = RD_DW / MIN_DW;
  localparam int TOTAL_UNITS = (2 ** WR_AW) * WR_UNITS;
  localparam int PW          = $clog2(TOTAL_UNITS);
  localparam int CNT_W       = PW + 1;

  localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL_UNITS);
  localparam logic [CNT_W-1:0] WR_C    = CNT_W'(WR_UNITS);
  localparam logic [CNT_W-1:0] RD_C    = CNT_W'(RD_UNITS);

  logic [MIN_DW-1:0] mem_q [TOTAL_UNITS];
  logic [MIN_DW-1:0] wr_unit [WR_UNITS];
  logic [RD_DW-1:0]  rd_word;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] level_q, level_d;
  logic             rd_valid_q, rd_valid_d;
  logic [RD_DW-1:0] rd_data_q, rd_data_d;

  logic [CNT_W-1:0] mem_cnt;
  logic             wr_ready, wr_fire, rd_fire, load;

  // Handshake decisions depend on registered state only, so a same-cycle read never frees write space.
  always_comb begin
    wr_ready = (TOTAL_C - level_q) >= WR_C;
    wr_fire  = bus.wr_valid && wr_ready;
    rd_fire  = rd_valid_q && bus.rd_ready;
    mem_cnt  = level_q - (rd_valid_q ? RD_C : '0);
    load     = (!rd_valid_q || bus.rd_ready) && (mem_cnt >= RD_C);
  end

  always_comb begin
    for (int k = 0; k < WR_UNITS; k++) begin
      if (LSB_FIRST) wr_unit[k] = bus.wr_data[k*MIN_DW +: MIN_DW];
      else           wr_unit[k] = bus.wr_data[(WR_UNITS-1-k)*MIN_DW +: MIN_DW];
    end
  end

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < RD_UNITS; k++) begin
      if (LSB_FIRST) rd_word[k*MIN_DW +: MIN_DW]              = mem_q[rd_ptr_q + PW'(k)];
      else           rd_word[(RD_UNITS-1-k)*MIN_DW +: MIN_DW] = mem_q[rd_ptr_q + PW'(k)];
    end
  end

  always_comb begin
    wr_ptr_d   = wr_fire ? wr_ptr_q + PW'(WR_UNITS) : wr_ptr_q;
    rd_ptr_d   = load ? rd_ptr_q + PW'(RD_UNITS) : rd_ptr_q;
    level_d    = level_q + (wr_fire ? WR_C : '0) - (rd_fire ? RD_C : '0);
    rd_valid_d = load || (rd_valid_q && !bus.rd_ready);
    rd_data_d  = load ? rd_word : rd_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Wide words are aligned to their own size, so the unit run never crosses the wrap.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int k = 0; k < WR_UNITS; k++) begin
        mem_q[wr_ptr_q + PW'(k)] <= wr_unit[k];
      end
    end
  end

  assign bus.wr_ready = wr_ready;
  assign bus.full     = !wr_ready;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.level    = level_q;
  assign bus.empty    = (level_q == '0);
endmodule

// File: tb/tb_asym_sync_fifo.sv
// Directed bench for asym_sync_fifo: three width/order configurations, a byte-stream
// scoreboard for the 32->8 instance, async reset mid-burst.
module tb_asym_sync_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  asym_sync_fifo_if #(.WR_DW(32), .RD_DW(8),  .CNT_W(9)) a_if ();
  asym_sync_fifo_if #(.WR_DW(32), .RD_DW(8),  .CNT_W(5)) b_if ();
  asym_sync_fifo_if #(.WR_DW(8),  .RD_DW(32), .CNT_W(5)) c_if ();

  asym_sync_fifo #(.WR_DW(32), .RD_DW(8), .WR_AW(6), .LSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if));
  asym_sync_fifo #(.WR_DW(32), .RD_DW(8), .WR_AW(2), .LSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if));
  asym_sync_fifo #(.WR_DW(8), .RD_DW(32), .WR_AW(4), .LSB_FIRST(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(c_if));

  int checks = 0;
  int errors = 0;

  // Reference model of instance A: byte stream order, level and output-stage occupancy.
  logic [7:0] exp_q[$];
  int         mlevel = 0;
  logic       mvalid = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    mlevel = 0;
    mvalid = 1'b0;
  endtask

  // One clock of instance A, checked against the model before and after the edge.
  task automatic a_cycle(input logic wv, input logic [31:0] wd, input logic rr);
    logic exp_rdy, wfire, rfire, load;
    int   mem_cnt;
    exp_rdy = (256 - mlevel) >= 4;
    check("a_wr_ready", a_if.wr_ready, exp_rdy);
    check("a_rd_valid", a_if.rd_valid, mvalid);
    if (mvalid) check("a_rd_data", a_if.rd_data, exp_q[0]);
    a_if.wr_valid = wv;
    a_if.wr_data  = wd;
    a_if.rd_ready = rr;
    wfire   = wv && exp_rdy;
    rfire   = mvalid && rr;
    mem_cnt = mlevel - (mvalid ? 1 : 0);
    load    = (!mvalid || rr) && (mem_cnt >= 1);
    tick();
    if (rfire) void'(exp_q.pop_front());
    if (wfire) for (int k = 0; k < 4; k++) exp_q.push_back(wd[8*k +: 8]);
    mvalid = load || (mvalid && !rr);
    mlevel = mlevel + (wfire ? 4 : 0) - (rfire ? 1 : 0);
    check("a_level", a_if.level, mlevel);
    a_if.wr_valid = 1'b0;
    a_if.rd_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b_exp [4];
    logic [7:0] held;
    int n;
    b_exp[0] = 8'h44; b_exp[1] = 8'h33; b_exp[2] = 8'h22; b_exp[3] = 8'h11;

    a_if.wr_valid = 1'b0; a_if.wr_data = '0; a_if.rd_ready = 1'b0;
    b_if.wr_valid = 1'b0; b_if.wr_data = '0; b_if.rd_ready = 1'b0;
    c_if.wr_valid = 1'b0; c_if.wr_data = '0; c_if.rd_ready = 1'b0;

    // Clock and reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_rd_valid", a_if.rd_valid, 1'b0);
    check("rst_a_rd_data",  a_if.rd_data, 8'h00);
    check("rst_a_level",    a_if.level, 9'd0);
    check("rst_a_wr_ready", a_if.wr_ready, 1'b1);
    check("rst_a_empty",    a_if.empty, 1'b1);
    check("rst_a_full",     a_if.full, 1'b0);
    check("rst_c_empty",    c_if.empty, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 32->8 LSB first, continuous consumer
    a_if.wr_valid = 1'b1; a_if.wr_data = 32'h44332211; a_if.rd_ready = 1'b1;
    tick();
    a_if.wr_valid = 1'b0;
    check("t1_rd_valid_e", a_if.rd_valid, 1'b0);
    check("t1_level_e",    a_if.level, 9'd4);
    check("t1_empty_e",    a_if.empty, 1'b0);
    tick();
    check("t1_rd_valid_e1", a_if.rd_valid, 1'b1);
    check("t1_data0",       a_if.rd_data, 8'h11);
    check("t1_level0",      a_if.level, 9'd4);
    for (int i = 1; i < 4; i++) begin
      tick();
      check("t1_valid", a_if.rd_valid, 1'b1);
      check("t1_data",  a_if.rd_data, 8'(8'h11 * (i + 1)));
      check("t1_level", a_if.level, 9'(4 - i));
    end
    tick();
    a_if.rd_ready = 1'b0;
    check("t1_valid_end", a_if.rd_valid, 1'b0);
    check("t1_level_end", a_if.level, 9'd0);
    check("t1_empty_end", a_if.empty, 1'b1);

    // 32->8 MSB first
    b_if.wr_valid = 1'b1; b_if.wr_data = 32'h44332211; b_if.rd_ready = 1'b1;
    tick();
    b_if.wr_valid = 1'b0;
    check("t2_rd_valid_e", b_if.rd_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_valid", b_if.rd_valid, 1'b1);
      check("t2_data",  b_if.rd_data, b_exp[i]);
      check("t2_level", b_if.level, 5'(4 - i));
    end
    tick();
    b_if.rd_ready = 1'b0;
    check("t2_empty_end", b_if.empty, 1'b1);

    // 8->32: partial word stays invisible until the fourth byte
    c_if.wr_valid = 1'b1;
    c_if.wr_data = 8'h11; tick();
    c_if.wr_data = 8'h22; tick();
    c_if.wr_data = 8'h33; tick();
    c_if.wr_valid = 1'b0;
    check("t3_partial_valid", c_if.rd_valid, 1'b0);
    check("t3_partial_level", c_if.level, 5'd3);
    check("t3_partial_empty", c_if.empty, 1'b0);
    tick();
    check("t3_partial_valid2", c_if.rd_valid, 1'b0);
    c_if.wr_valid = 1'b1; c_if.wr_data = 8'h44;
    tick();
    c_if.wr_valid = 1'b0;
    check("t3_valid_e",  c_if.rd_valid, 1'b0);
    check("t3_level_e",  c_if.level, 5'd4);
    tick();
    check("t3_valid_e1", c_if.rd_valid, 1'b1);
    check("t3_data",     c_if.rd_data, 32'h44332211);
    check("t3_level_e1", c_if.level, 5'd4);
    c_if.rd_ready = 1'b1;
    tick();
    c_if.rd_ready = 1'b0;
    check("t3_valid_end", c_if.rd_valid, 1'b0);
    check("t3_empty_end", c_if.empty, 1'b1);

    // Fill A to capacity: stream bytes are 0,1,2,...,255
    model_reset();
    for (int i = 0; i < 64; i++) begin
      a_cycle(1'b1, {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, 1'b0);
    end
    check("t4_level_full", a_if.level, 9'd256);
    check("t4_full",       a_if.full, 1'b1);
    a_cycle(1'b1, 32'hDEADBEEF, 1'b0);
    check("t4_ignored_level", a_if.level, 9'd256);
    check("t4_head", a_if.rd_data, 8'h00);
    for (int i = 0; i < 3; i++) a_cycle(1'b0, '0, 1'b1);
    check("t4_level_253",    a_if.level, 9'd253);
    check("t4_wr_ready_253", a_if.wr_ready, 1'b0);
    a_cycle(1'b0, '0, 1'b1);
    check("t4_level_252",    a_if.level, 9'd252);
    check("t4_wr_ready_252", a_if.wr_ready, 1'b1);
    check("t4_head_4",       a_if.rd_data, 8'h04);

    // Backpressure while writes keep arriving
    held = 8'h04;
    for (int i = 0; i < 5; i++) a_cycle(1'b1, $urandom, 1'b0);
    check("t5_hold_data",  a_if.rd_data, held);
    check("t5_hold_valid", a_if.rd_valid, 1'b1);

    // Three drain/fill passes across the pointer wrap
    for (int p = 0; p < 3; p++) begin
      n = 0;
      while ((mlevel != 0 || mvalid) && n < 600) begin
        a_cycle(1'b0, '0, 1'b1);
        n++;
      end
      check("t5_drain_bound", n < 600, 1'b1);
      check("t5_drained_empty", a_if.empty, 1'b1);
      n = 0;
      while (mlevel <= 252 && n < 400) begin
        a_cycle(1'b1, $urandom, $urandom_range(0, 3) == 0);
        n++;
      end
      check("t5_fill_bound", n < 400, 1'b1);
      check("t5_filled_full", a_if.full, 1'b1);
    end
    n = 0;
    while ((mlevel != 0 || mvalid) && n < 600) begin
      a_cycle(1'b0, '0, 1'b1);
      n++;
    end
    check("t5_final_drain", a_if.empty, 1'b1);

    // Async reset mid-burst with ten units held
    for (int i = 0; i < 3; i++) a_cycle(1'b1, 32'h0F0E0D0C + 32'(i), 1'b0);
    a_cycle(1'b0, '0, 1'b1);
    a_cycle(1'b0, '0, 1'b1);
    check("t6_level_10", a_if.level, 9'd10);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_rd_valid", a_if.rd_valid, 1'b0);
    check("t6_rst_rd_data",  a_if.rd_data, 8'h00);
    check("t6_rst_level",    a_if.level, 9'd0);
    check("t6_rst_wr_ready", a_if.wr_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    model_reset();
    a_cycle(1'b1, 32'hA1B2C3D4, 1'b1);
    a_cycle(1'b0, '0, 1'b1);
    check("t6_first_after_rst", a_if.rd_data, 8'hD4);
    for (int i = 0; i < 5; i++) a_cycle(1'b0, '0, 1'b1);
    check("t6_empty_end", a_if.empty, 1'b1);
    check("t6_level_end", a_if.level, 9'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
